// File: rtl/nios2_div_cell.sv
// nios2_div_cell: iterative radix-2 non-restoring divider for div/divu.
// One quotient bit per cycle over operand magnitudes, then a sign-fix cycle.
module nios2_div_cell #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E_div_start,
  input  logic             E_ctrl_div_signed,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_div_abort,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_quot,
  output logic [WIDTH-1:0] M_div_rem
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   dvs;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] raw_dvd;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;

  logic             load_c;
  logic             iter_c;
  logic             fix_c;
  logic             abort_c;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quot_res;
  logic [WIDTH-1:0] rem_res;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort only matters once an operation is in flight
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (E_div_start) state_nxt = S_ITER;
      S_ITER: begin
        if (E_div_abort)    state_nxt = S_IDLE;
        else if (cnt == '0) state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath control decode from current state
  always_comb begin
    load_c  = 1'b0;
    iter_c  = 1'b0;
    fix_c   = 1'b0;
    abort_c = 1'b0;
    case (state)
      S_IDLE: load_c = E_div_start;
      S_ITER: begin
        iter_c  = ~E_div_abort;
        abort_c = E_div_abort;
      end
      S_FIX: begin
        fix_c   = ~E_div_abort;
        abort_c = E_div_abort;
      end
      default: ;
    endcase
  end

  // Operand magnitudes, one iteration step, and final sign correction
  always_comb begin
    dvd_mag  = (E_ctrl_div_signed & E_src1[WIDTH-1]) ? WIDTH'(WIDTH'(0) - E_src1) : E_src1;
    dvs_mag  = (E_ctrl_div_signed & E_src2[WIDTH-1]) ? WIDTH'(WIDTH'(0) - E_src2) : E_src2;
    shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    rem_step = rem[WIDTH] ? (WIDTH+1)'(shifted + dvs) : (WIDTH+1)'(shifted - dvs);
    rem_fix  = rem[WIDTH] ? WIDTH'(rem[WIDTH-1:0] + dvs[WIDTH-1:0]) : rem[WIDTH-1:0];
    quot_res = q_neg ? WIDTH'(WIDTH'(0) - quo) : quo;
    rem_res  = r_neg ? WIDTH'(WIDTH'(0) - rem_fix) : rem_fix;
    if (div_zero) begin
      quot_res = '1;
      rem_res  = raw_dvd;
    end
  end

  // Operand latch, iteration registers and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      rem        <= '0;
      dvs        <= '0;
      quo        <= '0;
      raw_dvd    <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_zero   <= 1'b0;
      M_div_busy <= 1'b0;
      M_div_done <= 1'b0;
      M_div_quot <= '0;
      M_div_rem  <= '0;
    end else begin
      M_div_done <= fix_c;
      if (load_c) begin
        rem        <= '0;
        quo        <= dvd_mag;
        dvs        <= {1'b0, dvs_mag};
        raw_dvd    <= E_src1;
        q_neg      <= E_ctrl_div_signed & (E_src1[WIDTH-1] ^ E_src2[WIDTH-1]);
        r_neg      <= E_ctrl_div_signed & E_src1[WIDTH-1];
        div_zero   <= (E_src2 == '0);
        cnt        <= CW'(WIDTH - 1);
        M_div_busy <= 1'b1;
      end
      if (iter_c) begin
        rem <= rem_step;
        quo <= {quo[WIDTH-2:0], ~rem_step[WIDTH]};
        if (cnt != '0) cnt <= CW'(cnt - CW'(1));
      end
      if (fix_c) begin
        M_div_quot <= quot_res;
        M_div_rem  <= rem_res;
      end
      if (fix_c | abort_c) M_div_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios2_div_cell.sv
// tb_nios2_div_cell: directed vectors plus multi-cycle corner sequences.
module tb_nios2_div_cell;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sgn;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[12];

  nios2_div_cell #(.WIDTH(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .E_div_start       (start),
    .E_ctrl_div_signed (sgn),
    .E_src1            (src1),
    .E_src2            (src2),
    .E_div_abort       (abort),
    .M_div_busy        (busy),
    .M_div_done        (done),
    .M_div_quot        (quot),
    .M_div_rem         (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge: presents one start, scrambles operands, waits for done.
  task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic with_abort, output int lat, output logic busy_ok);
    start = 1'b1; sgn = sg; src1 = a; src2 = b; abort = with_abort;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; sgn = ~sg; src1 = 32'hDEAD_BEEF; src2 = 32'h0000_0003;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic bok;
    int   ndone;

    n_cmp = 0; n_bad = 0;
    start = 0; sgn = 0; src1 = 0; src2 = 0; abort = 0; reset = 1;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h2,          32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2]  = '{1'b1, 32'h7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'h1};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF,   32'h1,          32'hFFFFFFFF,   32'h0};
    vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h0};
    vecs[5]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5};
    vecs[6]  = '{1'b1, 32'h12345678,   32'h0,          32'hFFFFFFFF,   32'h12345678};
    vecs[7]  = '{1'b0, 32'h80000000,   32'h0,          32'hFFFFFFFF,   32'h80000000};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
    vecs[9]  = '{1'b0, 32'hFFFFFFF9,   32'h2,          32'h7FFFFFFC,   32'h1};
    vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h1,          32'h0};
    vecs[11] = '{1'b1, 32'h80000000,   32'h1,          32'h80000000,   32'h0};

    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quot", quot, 32'd0);
    check("reset_rem",  rem,  32'd0);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].sg, vecs[i].a, vecs[i].b, 1'b0, lat, bok);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
      check($sformatf("v%0d_busy_window", i), 32'(bok), 32'd1);
      check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_quot", i), quot, vecs[i].q);
      check($sformatf("v%0d_rem", i), rem, vecs[i].r);
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
    end

    // Start re-asserted at cycles 5 and 20 is ignored
    start = 1; sgn = 0; src1 = 32'd100; src2 = 32'd7;
    @(negedge clk);
    start = 0;
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 5 || lat == 20) begin
        start = 1; sgn = 1; src1 = 32'd999; src2 = 32'd4;
      end else begin
        start = 0;
      end
      @(negedge clk);
      lat++;
    end
    start = 0;
    check("restart_latency", 32'(lat), 32'd33);
    check("restart_quot", quot, 32'd14);
    check("restart_rem",  rem,  32'd2);

    // Start in the done cycle is accepted
    launch(1'b0, 32'd1000, 32'd10, 1'b0, lat, bok);
    check("b2b_latency", 32'(lat), 32'd33);
    check("b2b_quot", quot, 32'd100);
    check("b2b_rem",  rem,  32'd0);

    // Abort at cycle 10: no done, results retained
    @(negedge clk);
    start = 1; sgn = 0; src1 = 32'd50; src2 = 32'd3;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quot", quot, 32'd100);
    check("abort_rem",  rem,  32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    // Abort together with start in IDLE: start wins
    launch(1'b0, 32'd77, 32'd10, 1'b1, lat, bok);
    check("abort_start_latency", 32'(lat), 32'd33);
    check("abort_start_quot", quot, 32'd7);
    check("abort_start_rem",  rem,  32'd7);

    // Reset at cycle 10 clears outputs, then a fresh divide works
    @(negedge clk);
    start = 1; sgn = 1; src1 = 32'd123; src2 = 32'd5;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_quot", quot, 32'd0);
    check("midreset_rem",  rem,  32'd0);
    launch(1'b1, 32'h7, 32'hFFFFFFFE, 1'b0, lat, bok);
    check("post_reset_latency", 32'(lat), 32'd33);
    check("post_reset_quot", quot, 32'hFFFFFFFD);
    check("post_reset_rem",  rem,  32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
